// File: rtl/trace_pkg.sv
// Shared definitions for the pipeline trace buffer: capture FSM encoding,
// flag bit positions within a record, and the halt opcode used as a trigger.
// No ports; imported by pipeline_trace_buffer.
package trace_pkg;

  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_ARMED = 2'd1,
    TRC_POST  = 2'd2,
    TRC_DONE  = 2'd3
  } trc_state_t;

  // Bit positions inside the 4-bit flags field of a record.
  localparam int FLG_FLUSH   = 3;
  localparam int FLG_BUBBLE  = 2;
  localparam int FLG_PCWRITE = 1;
  localparam int FLG_PRED    = 0;

  // Opcode field value that halts the core and fires the trigger.
  localparam logic [6:0] HALT_OPCODE = 7'h7F;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port DEPTH x WIDTH storage for trace records.
// Ports: clk; we/waddr/wdata synchronous write; re/raddr read request,
// rdata registered one cycle after re. Contents are never reset.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 68
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Circular trace buffer for the IF/ID boundary: records {[cycle], pc, instr,
// flags} each enabled cycle, freezes POST_TRIG records after a halt-opcode or
// PC-match trigger, then serves reads with 1-cycle latency (rd_req -> rd_valid).
// Ports: clk/rst (sync, active high), enable, arm, pc/instr/flags capture
// inputs, trig_pc_en/trig_pc, rd_req/rd_idx -> rd_valid/rd_data, and the
// registered status outputs state, count, trig_cause.
// Build option: define TRACE_CYCLE_STAMP_EN to prefix each record with a
// CYC_W-bit free-running cycle stamp.
module pipeline_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int POST_TRIG = 8,
  parameter int CYC_W     = 16,
  localparam int AW       = $clog2(DEPTH),
  // The stamp field has zero width when the cycle counter is compiled out.
  localparam int STAMP_W  =
`ifdef TRACE_CYCLE_STAMP_EN
    CYC_W,
`else
    0 * CYC_W,
`endif
  localparam int ENTRY_W  = STAMP_W + PC_W + INSTR_W + 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               arm,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic [3:0]         flags,
  input  logic               trig_pc_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_idx,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [1:0]         state,
  output logic [AW:0]        count,
  output logic [1:0]         trig_cause
);

  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  trc_state_t         state_q, state_d;
  logic [AW-1:0]      wr_ptr_q;
  logic [AW:0]        count_q;
  logic [AW-1:0]      post_cnt_q;
  logic [1:0]         cause_q;
  logic               rd_valid_q;
  logic               oob_q;

  logic               hit_halt, hit_pc;
  logic               capture, trigger, rd_fire;
  logic [AW-1:0]      oldest, raddr;
  logic [ENTRY_W-1:0] wdata, ram_rdata;

  assign hit_halt = (instr[6:0] == HALT_OPCODE);
  assign hit_pc   = trig_pc_en && (pc == trig_pc);

  // arm wins over everything else in its cycle, so it also blocks capture.
  assign capture = enable && !arm &&
                   ((state_q == TRC_ARMED) || (state_q == TRC_POST));
  assign trigger = capture && (state_q == TRC_ARMED) && (hit_halt || hit_pc);
  assign rd_fire = rd_req && !arm && (state_q == TRC_DONE);

  // Until the buffer has wrapped, the oldest record sits in slot 0.
  assign oldest = (count_q < DEPTH_CNT) ? '0 : wr_ptr_q;
  assign raddr  = oldest + rd_idx;

`ifdef TRACE_CYCLE_STAMP_EN
  logic [CYC_W-1:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

  assign wdata = {cyc_q, pc, instr, flags};
`else
  assign wdata = {pc, instr, flags};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      TRC_IDLE:  state_d = TRC_IDLE;
      TRC_ARMED: begin
        if (trigger) begin
          state_d = (POST_TRIG == 0) ? TRC_DONE : TRC_POST;
        end
      end
      TRC_POST: begin
        if (capture && (post_cnt_q == AW'(1))) begin
          state_d = TRC_DONE;
        end
      end
      TRC_DONE:  state_d = TRC_DONE;
      default:   state_d = TRC_IDLE;
    endcase
    if (arm) begin
      state_d = TRC_ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TRC_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      cause_q    <= '0;
      rd_valid_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        wr_ptr_q   <= '0;
        count_q    <= '0;
        post_cnt_q <= '0;
        cause_q    <= '0;
      end else if (capture) begin
        // DEPTH is a power of two, so the pointer wraps on its own.
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (count_q != DEPTH_CNT) begin
          count_q <= count_q + 1'b1;
        end
        if (trigger) begin
          cause_q    <= {hit_pc, hit_halt};
          post_cnt_q <= POST_INIT;
        end else if (state_q == TRC_POST) begin
          post_cnt_q <= post_cnt_q - 1'b1;
        end
      end
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        oob_q <= ({1'b0, rd_idx} >= count_q);
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (capture),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .re    (rd_fire),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  // Out-of-range reads return zero; data is also zero whenever not valid.
  assign rd_data    = (rd_valid_q && !oob_q) ? ram_rdata : '0;
  assign rd_valid   = rd_valid_q;
  assign state      = state_q;
  assign count      = count_q;
  assign trig_cause = cause_q;

endmodule
